// File: rtl/soc_addr_pkg.sv
// Shared SoC address-map constants and decode helpers for the data-SRAM responder.
// Keeps the confreg window layout in one place for the top and any future peers.
package soc_addr_pkg;

    localparam int          RAM_AW_DEFAULT = 14;
    localparam logic [15:0] CONF_HI        = 16'hBFAF;
    localparam logic [15:0] LED_OFF        = 16'hF020;
    localparam logic [15:0] SWITCH_OFF     = 16'hF02C;
    localparam logic [15:0] TIMER_OFF      = 16'hE000;

    // Source of the read data returned one cycle after a request.
    typedef enum logic [2:0] {
        SEL_ZERO,
        SEL_RAM,
        SEL_LED,
        SEL_SW,
        SEL_TIMER
    } sel_e;

    function automatic sel_e decode_sel(input logic conf, input logic [15:0] off);
        sel_e sel;
        sel = SEL_ZERO;
        if (!conf) begin
            sel = SEL_RAM;
        end else begin
            case (off)
                LED_OFF:    sel = SEL_LED;
                SWITCH_OFF: sel = SEL_SW;
                TIMER_OFF:  sel = SEL_TIMER;
                default:    sel = SEL_ZERO;
            endcase
        end
        return sel;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  we);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                res[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_bytewe_ram.sv
// Single-port synchronous RAM, read-first, with four byte-lane write enables.
// Each lane is its own array so tools map it onto byte-wide block RAM columns.
module sram_bytewe_ram #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    localparam int DEPTH = 1 << AW;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] dout_q;

            // The read samples the old word even when this lane is written.
            always_ff @(posedge clk) begin
                if (en) begin
                    if (we[gi]) begin
                        mem[addr] <= wdata[gi*8 +: 8];
                    end
                    dout_q <= mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = dout_q;
        end
    endgenerate

endmodule

// File: rtl/data_sram_responder.sv
// Responder side of the CPU data-SRAM port: data RAM plus LED/switch/timer confreg
// window, returning read data exactly one cycle after each request.
module data_sram_responder #(
    parameter int          RAM_AW  = soc_addr_pkg::RAM_AW_DEFAULT,
    parameter logic [15:0] CONF_HI = soc_addr_pkg::CONF_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sram_en,
    input  logic [3:0]  sram_we,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led_out,
    output logic [31:0] timer_out
);

    import soc_addr_pkg::*;

    logic        conf_hit;
    logic [15:0] conf_off;
    logic        wr_req;
    logic        led_wr;
    logic        timer_wr;
    logic        ram_en;
    logic [31:0] ram_rdata;
    sel_e        sel_d;
    sel_e        sel_q;
    logic [31:0] conf_rdata_d;
    logic [31:0] conf_rdata_q;
    logic [15:0] led_d;
    logic [15:0] led_q;
    logic [31:0] timer_d;
    logic [31:0] timer_q;
    logic        valid_q;
    logic [31:0] rdata_d;
    logic [31:0] hold_q;
    logic        unused_addr_lsb;

    assign conf_hit        = (sram_addr[31:16] == CONF_HI);
    assign conf_off        = sram_addr[15:0];
    assign wr_req          = sram_en && (sram_we != 4'b0000);
    assign led_wr          = wr_req && conf_hit && (conf_off == LED_OFF);
    assign timer_wr        = wr_req && conf_hit && (conf_off == TIMER_OFF);
    assign ram_en          = sram_en && !conf_hit && !reset;
    assign unused_addr_lsb = ^sram_addr[1:0];

    sram_bytewe_ram #(
        .AW(RAM_AW)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (sram_we),
        .addr (sram_addr[RAM_AW+1:2]),
        .wdata(sram_wdata),
        .rdata(ram_rdata)
    );

    // Confreg read values are captured in the request cycle, before any write lands.
    always_comb begin
        sel_d        = decode_sel(conf_hit, conf_off);
        conf_rdata_d = '0;
        case (sel_d)
            SEL_LED:   conf_rdata_d = {16'h0000, led_q};
            SEL_SW:    conf_rdata_d = {24'h000000, switch_in};
            SEL_TIMER: conf_rdata_d = timer_q;
            default:   conf_rdata_d = '0;
        endcase
        timer_d = timer_wr ? merge_bytes(timer_q, sram_wdata, sram_we) : timer_q + 32'd1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_led_lane
            assign led_d[gi*8 +: 8] = (led_wr && sram_we[gi]) ? sram_wdata[gi*8 +: 8]
                                                              : led_q[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        rdata_d = hold_q;
        if (valid_q) begin
            case (sel_q)
                SEL_RAM:  rdata_d = ram_rdata;
                SEL_ZERO: rdata_d = '0;
                default:  rdata_d = conf_rdata_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q        <= '0;
            timer_q      <= '0;
            sel_q        <= SEL_ZERO;
            conf_rdata_q <= '0;
            valid_q      <= 1'b0;
            hold_q       <= '0;
        end else begin
            led_q   <= led_d;
            timer_q <= timer_d;
            valid_q <= sram_en;
            hold_q  <= rdata_d;
            if (sram_en) begin
                sel_q        <= sel_d;
                conf_rdata_q <= conf_rdata_d;
            end
        end
    end

    assign sram_rdata = rdata_d;
    assign led_out    = led_q;
    assign timer_out  = timer_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: expected read data is queued when a
// request is driven and compared on the falling edge after the response cycle.
module tb_data_sram_responder;

    logic        clk;
    logic        reset;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [7:0]  switch_in;
    logic [15:0] led_out;
    logic [31:0] timer_out;

    localparam logic [31:0] ADDR_A   = 32'h1C000100;
    localparam logic [31:0] ADDR_B   = 32'h1C000200;
    localparam logic [31:0] ADDR_BTB = 32'h1C001000;
    localparam logic [31:0] ADDR_LED = 32'hBFAFF020;
    localparam logic [31:0] ADDR_SW  = 32'hBFAFF02C;
    localparam logic [31:0] ADDR_TMR = 32'hBFAFE000;
    localparam logic [31:0] ADDR_UNM = 32'hBFAF0000;

    typedef struct {
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk;
        logic [31:0] exp;
    } step_t;

    typedef struct {
        bit          chk;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    data_sram_responder dut (
        .clk       (clk),
        .reset     (reset),
        .sram_en   (sram_en),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .switch_in (switch_in),
        .led_out   (led_out),
        .timer_out (timer_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic step_t mk(input logic en, input logic [3:0] we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit chk, input logic [31:0] exp);
        step_t s;
        s.en = en; s.we = we; s.addr = addr; s.wdata = wdata; s.chk = chk; s.exp = exp;
        return s;
    endfunction

    function automatic logic [31:0] tb_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] we);
        logic [31:0] r;
        r = o;
        if (we[0]) r[7:0]   = n[7:0];
        if (we[1]) r[15:8]  = n[15:8];
        if (we[2]) r[23:16] = n[23:16];
        if (we[3]) r[31:24] = n[31:24];
        return r;
    endfunction

    task automatic drive(input step_t s, input string name);
        sram_en    = s.en;
        sram_we    = s.we;
        sram_addr  = s.addr;
        sram_wdata = s.wdata;
        if (s.en) exp_q.push_back('{s.chk, s.exp, name});
    endtask

    task automatic drive_idle();
        sram_en    = 1'b0;
        sram_we    = 4'h0;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sram_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h expected %h", sram_rdata, 32'h0);
        end
        n_checks++;
        if (led_out !== 16'h0) begin
            n_fail++; $display("FAIL reset_led: got %h expected %h", led_out, 16'h0);
        end
        n_checks++;
        if (timer_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_timer: got %h expected %h", timer_out, 32'h0);
        end
        reset = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (timer_out !== 32'(k)) begin
                n_fail++; $display("FAIL timer_count%0d: got %h expected %h", k, timer_out, 32'(k));
            end
        end
    endtask

    task automatic test_ram();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1, 4'hF, ADDR_A, 32'h12345678, 0, 32'h0));
        s.push_back(mk(1, 4'h0, ADDR_A, 32'h0,        1, 32'h12345678));
        s.push_back(mk(1, 4'h2, ADDR_A, 32'hAABBCCDD, 1, 32'h12345678));
        s.push_back(mk(1, 4'h0, ADDR_A, 32'h0,        1, 32'h1234CC78));
        s.push_back(mk(1, 4'h9, ADDR_A, 32'h11223344, 1, 32'h1234CC78));
        s.push_back(mk(1, 4'h0, ADDR_A, 32'h0,        1, 32'h1134CC44));
        for (int i = 0; i <= s.size(); i++) begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    n_checks++;
                    if (sram_rdata !== e.data) begin
                        n_fail++; $display("FAIL %s: got %h expected %h", e.name, sram_rdata, e.data);
                    end else $display("%s: rdata=%h", e.name, sram_rdata);
                end
            end
            if (i < s.size()) drive(s[i], $sformatf("ram_step%0d", i)); else drive_idle();
        end
    endtask

    task automatic test_led();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1, 4'hF, ADDR_LED, 32'hFFFF00A5, 1, 32'h00000000));
        s.push_back(mk(1, 4'h0, ADDR_LED, 32'h0,        1, 32'h000000A5));
        s.push_back(mk(1, 4'h2, ADDR_LED, 32'h00003C00, 1, 32'h000000A5));
        s.push_back(mk(1, 4'hC, ADDR_LED, 32'hFFFFFFFF, 1, 32'h00003CA5));
        s.push_back(mk(1, 4'h0, ADDR_LED, 32'h0,        1, 32'h00003CA5));
        for (int i = 0; i <= s.size(); i++) begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    n_checks++;
                    if (sram_rdata !== e.data) begin
                        n_fail++; $display("FAIL %s: got %h expected %h", e.name, sram_rdata, e.data);
                    end else $display("%s: rdata=%h", e.name, sram_rdata);
                end
            end
            if (i == 1 || i == 5) begin
                n_checks++;
                if (led_out !== ((i == 1) ? 16'h00A5 : 16'h3CA5)) begin
                    n_fail++;
                    $display("FAIL led_out_step%0d: got %h expected %h", i, led_out,
                             (i == 1) ? 16'h00A5 : 16'h3CA5);
                end
            end
            if (i < s.size()) drive(s[i], $sformatf("led_step%0d", i)); else drive_idle();
        end
    endtask

    task automatic test_timer();
        step_t       s[$];
        exp_t        e;
        logic [31:0] tmr_exp [7];
        tmr_exp = '{32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h0000BEEF, 32'h0000BEF0};
        s.push_back(mk(1, 4'hF, ADDR_TMR, 32'hFFFFFFFE, 0, 32'h0));
        s.push_back(mk(0, 4'h0, 32'h0,    32'h0,        0, 32'h0));
        s.push_back(mk(1, 4'h0, ADDR_TMR, 32'h0,        1, 32'hFFFFFFFF));
        s.push_back(mk(0, 4'h0, 32'h0,    32'h0,        0, 32'h0));
        s.push_back(mk(1, 4'h3, ADDR_TMR, 32'h5555BEEF, 1, 32'h00000001));
        s.push_back(mk(0, 4'h0, 32'h0,    32'h0,        0, 32'h0));
        for (int i = 0; i <= s.size(); i++) begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    n_checks++;
                    if (sram_rdata !== e.data) begin
                        n_fail++; $display("FAIL %s: got %h expected %h", e.name, sram_rdata, e.data);
                    end else $display("%s: rdata=%h", e.name, sram_rdata);
                end
            end
            if (i >= 1) begin
                n_checks++;
                if (timer_out !== tmr_exp[i]) begin
                    n_fail++; $display("FAIL timer_step%0d: got %h expected %h", i, timer_out, tmr_exp[i]);
                end
            end
            if (i < s.size()) drive(s[i], $sformatf("timer_step%0d", i)); else drive_idle();
        end
    endtask

    task automatic test_switch();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1, 4'h0, ADDR_SW,  32'h0,        1, 32'h0000005A));
        s.push_back(mk(1, 4'hF, ADDR_SW,  32'hFFFFFFFF, 1, 32'h0000005A));
        s.push_back(mk(1, 4'h0, ADDR_SW,  32'h0,        1, 32'h0000005A));
        s.push_back(mk(1, 4'h0, ADDR_UNM, 32'h0,        1, 32'h00000000));
        s.push_back(mk(1, 4'hF, ADDR_UNM, 32'h12345678, 1, 32'h00000000));
        s.push_back(mk(1, 4'h0, ADDR_UNM, 32'h0,        1, 32'h00000000));
        s.push_back(mk(1, 4'h0, ADDR_SW,  32'h0,        1, 32'h000000C3));
        for (int i = 0; i <= s.size(); i++) begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    n_checks++;
                    if (sram_rdata !== e.data) begin
                        n_fail++; $display("FAIL %s: got %h expected %h", e.name, sram_rdata, e.data);
                    end else $display("%s: rdata=%h", e.name, sram_rdata);
                end
            end
            if (i == 6) switch_in = 8'hC3;
            if (i < s.size()) drive(s[i], $sformatf("switch_step%0d", i)); else drive_idle();
        end
    endtask

    task automatic test_back_to_back();
        step_t       s[$];
        exp_t        e;
        logic [31:0] ref_m [8];
        logic [31:0] d;
        logic [3:0]  we;
        for (int k = 0; k < 8; k++) begin
            d = $urandom;
            ref_m[k] = d;
            s.push_back(mk(1, 4'hF, ADDR_BTB + 32'(4 * k), d, 0, 32'h0));
        end
        for (int k = 0; k < 8; k++) begin
            d  = $urandom;
            we = 4'($urandom_range(1, 15));
            s.push_back(mk(1, we, ADDR_BTB + 32'(4 * k), d, 1, ref_m[k]));
            ref_m[k] = tb_merge(ref_m[k], d, we);
        end
        for (int k = 0; k < 8; k++) begin
            s.push_back(mk(1, 4'h0, ADDR_BTB + 32'(4 * k), 32'h0, 1, ref_m[k]));
        end
        for (int k = 0; k < 4; k++) begin
            d = $urandom;
            s.push_back(mk(1, 4'hF, ADDR_BTB + 32'(4 * k), d, 1, ref_m[k]));
            ref_m[k] = d;
            s.push_back(mk(1, 4'h0, ADDR_BTB + 32'(4 * k), 32'h0, 1, d));
        end
        for (int i = 0; i <= s.size(); i++) begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    n_checks++;
                    if (sram_rdata !== e.data) begin
                        n_fail++; $display("FAIL %s: got %h expected %h", e.name, sram_rdata, e.data);
                    end else $display("%s: rdata=%h", e.name, sram_rdata);
                end
            end
            if (i < s.size()) drive(s[i], $sformatf("b2b_step%0d", i)); else drive_idle();
        end
    endtask

    task automatic test_reset_request();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1, 4'hF, ADDR_B,   32'hDEADBEEF, 0, 32'h0));
        s.push_back(mk(1, 4'h0, ADDR_B,   32'h0,        1, 32'hDEADBEEF));
        s.push_back(mk(0, 4'h0, 32'h0,    32'h0,        0, 32'h0));
        s.push_back(mk(0, 4'h0, 32'h0,    32'h0,        0, 32'h0));
        s.push_back(mk(1, 4'hF, ADDR_LED, 32'h0000FFFF, 1, 32'h00003CA5));
        for (int i = 0; i <= s.size(); i++) begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    n_checks++;
                    if (sram_rdata !== e.data) begin
                        n_fail++; $display("FAIL %s: got %h expected %h", e.name, sram_rdata, e.data);
                    end else $display("%s: rdata=%h", e.name, sram_rdata);
                end
            end
            if (i == 3 || i == 4) begin
                n_checks++;
                if (sram_rdata !== 32'hDEADBEEF) begin
                    n_fail++; $display("FAIL rdata_hold%0d: got %h expected %h", i, sram_rdata, 32'hDEADBEEF);
                end
            end
            if (i < s.size()) drive(s[i], $sformatf("rst_step%0d", i)); else drive_idle();
        end
        @(negedge clk);
        reset      = 1'b1;
        sram_en    = 1'b1;
        sram_we    = 4'hF;
        sram_addr  = ADDR_B;
        sram_wdata = 32'h0BADF00D;
        @(negedge clk);
        n_checks++;
        if (sram_rdata !== 32'h0) begin
            n_fail++; $display("FAIL rst_req_rdata: got %h expected %h", sram_rdata, 32'h0);
        end
        n_checks++;
        if (led_out !== 16'h0) begin
            n_fail++; $display("FAIL rst_req_led: got %h expected %h", led_out, 16'h0);
        end
        n_checks++;
        if (timer_out !== 32'h0) begin
            n_fail++; $display("FAIL rst_req_timer: got %h expected %h", timer_out, 32'h0);
        end
        reset      = 1'b0;
        sram_we    = 4'h0;
        sram_wdata = 32'h0;
        @(negedge clk);
        drive_idle();
        n_checks++;
        if (sram_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL rst_req_ram_kept: got %h expected %h", sram_rdata, 32'hDEADBEEF);
        end else $display("rst_req_ram_kept: rdata=%h", sram_rdata);
    endtask

    initial begin
        reset      = 1'b1;
        sram_en    = 1'b0;
        sram_we    = 4'h0;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        switch_in  = 8'h5A;
        test_reset();
        test_ram();
        test_led();
        test_timer();
        test_switch();
        test_back_to_back();
        test_reset_request();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
